iter_divider: RTL and testbench
===============================

# iter_divider

Native, parametrised radix-2 restoring divider for the EXE stage, replacing vendor-IP-based division. Accepts one signed or unsigned WIDTH-bit division per valid/ready handshake, iterates one quotient bit per cycle, and holds a {remainder, quotient} result until the consumer accepts it. A synchronous cancel supports pipeline flush on exceptions.

## Interface
- WIDTH, 32, operand width in bits (≥ 2).
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- div_op  in  2  bit0 = signed, bit1 = unsigned; bit0 wins if both set; 2'b00 treated as unsigned; sampled at acceptance only.
- dividend  in  WIDTH  dividend.
- divisor  in  WIDTH  divisor.
- div_in_valid  in  1  request valid.
- div_in_ready  out  1  request can be accepted this cycle.
- div_cancel  in  1  abort any in-flight or completed-but-unconsumed division.
- div_result  out  2*WIDTH  {remainder, quotient}: remainder in [2*WIDTH-1:WIDTH] (HI), quotient in [WIDTH-1:0] (LO).
- div_out_valid  out  1  div_result valid.
- div_out_ready  in  1  consumer accepts result.

## Operation
- States: IDLE, BUSY, DONE.
- Acceptance = div_in_valid && div_in_ready && !div_cancel. Latch op, |dividend|, |divisor|, sign of dividend, sign of quotient (dividend sign XOR divisor sign, signed only). Load iteration counter with WIDTH, go BUSY.
- BUSY: each cycle shift partial remainder left by one, pulling in next dividend MSB; trial-subtract |divisor|; if no borrow, keep the difference and shift in quotient bit 1, else shift in 0. Decrement counter. Partial remainder is WIDTH+1 bits. On counter reaching 0, go DONE.
- DONE: div_out_valid = 1. On div_out_ready, go IDLE, or back to BUSY if a new request is accepted the same cycle.
- div_in_ready = (state == IDLE) || (state == DONE && div_out_ready).
- Sign fix is combinational on the output: quotient negated if quotient-sign set; remainder negated if dividend was negative. The remainder's sign follows the dividend.
- Signed MIN / -1: quotient = MIN (0x80000000 for WIDTH=32), remainder = 0. No trap.
- Divide by zero, either op: quotient = all ones, remainder = original dividend. This value is forced, independent of sign fix.
- div_cancel, any state: next state IDLE, div_out_valid low next cycle, result discarded. A request presented in the cancel cycle is not accepted.
- div_result is don't-care when div_out_valid = 0. It is held stable while DONE && !div_out_ready.

## Timing
- Reset (async assert): state IDLE; div_in_ready = 1, div_out_valid = 0, div_result = 0. Counter and datapath registers cleared.
- Reset asserted mid-BUSY/DONE: immediate return to IDLE; the operation is lost.
- Latency: accept in cycle 0; iterations in cycles 1..WIDTH; div_out_valid first high in cycle WIDTH+1 (33 for WIDTH=32).
- Throughput: back-to-back, one result per WIDTH+1 cycles, with no bubble when div_out_ready is high in DONE.
- div_out_valid stays high until handshake or cancel. No combinational path from div_in_valid to div_out_valid.

## Configuration
- DIV_EARLY_OUT_EN defined: at acceptance, if divisor == 0 or |dividend| < |divisor|, skip BUSY and go straight to DONE. div_out_valid is then high in cycle 1.
  - Divide by zero returns the forced values above.
  - The |dividend| < |divisor| case returns quotient 0, remainder = dividend.
- DIV_EARLY_OUT_EN undefined: every division takes the full WIDTH+1 cycles. Results are identical either way.

## Test plan
- Unsigned, WIDTH=32: 100 / 7 -> result {0x00000002, 0x0000000E}, div_out_valid first high in cycle 33.
- Signed: -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 5 / 0 -> quotient 0xFFFFFFFF, remainder 5.
- Hold div_out_ready low 10 cycles in DONE -> div_out_valid and div_result stable, div_in_ready low. Then assert div_out_ready with a new div_in_valid in the same cycle -> second request accepted, second result 33 cycles later.
- Assert div_cancel in cycle 15 of BUSY -> div_out_valid never rises, div_in_ready = 1 next cycle. Deassert resetn mid-BUSY -> outputs return to reset values immediately.
- With DIV_EARLY_OUT_EN: unsigned 3 / 10 -> {0x00000003, 0x00000000} with div_out_valid in cycle 1. Without the macro: same result in cycle 33.

Source files
------------

// File: rtl/iter_divider_if.sv
// Request/response bundle for iter_divider: operands and op select in,
// {remainder, quotient} out, each side with its own valid/ready pair.
interface iter_divider_if #(
  parameter int WIDTH = 32
) ();
  logic [1:0]         div_op;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               div_in_valid;
  logic               div_in_ready;
  logic               div_cancel;
  logic [2*WIDTH-1:0] div_result;
  logic               div_out_valid;
  logic               div_out_ready;

  modport master (
    output div_op, dividend, divisor, div_in_valid, div_cancel, div_out_ready,
    input  div_in_ready, div_result, div_out_valid
  );

  modport slave (
    input  div_op, dividend, divisor, div_in_valid, div_cancel, div_out_ready,
    output div_in_ready, div_result, div_out_valid
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider, signed/unsigned, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: finish at acceptance for x/0 and |dividend| < |divisor|.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         resetn,
  iter_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_rem_r, neg_quo_r, dvz_r;

  logic             signed_s, a_neg_s, b_neg_s, in_ready_s, accept_s, early_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s, q_fix_s, r_fix_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH+1:0] diff_s;

  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1'b1);
  endfunction

  // Operand conditioning, handshake and one trial-subtract step
  always_comb begin
    signed_s   = bus.div_op[0];
    a_neg_s    = signed_s & bus.dividend[WIDTH-1];
    b_neg_s    = signed_s & bus.divisor[WIDTH-1];
    abs_a_s    = a_neg_s ? neg2(bus.dividend) : bus.dividend;
    abs_b_s    = b_neg_s ? neg2(bus.divisor) : bus.divisor;
    in_ready_s = (state_r == IDLE) || ((state_r == DONE) && bus.div_out_ready);
    accept_s   = bus.div_in_valid && in_ready_s && !bus.div_cancel;
`ifdef DIV_EARLY_OUT_EN
    early_s    = (bus.divisor == {WIDTH{1'b0}}) || (abs_a_s < abs_b_s);
`else
    early_s    = 1'b0;
`endif
    shift_s    = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
    diff_s     = {1'b0, shift_s} - {2'b00, dsr_r};
  end

  // Next-state logic; cancel overrides everything
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = early_s ? DONE : BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == CW'(1)) state_nxt_s = DONE;
        else                 state_nxt_s = BUSY;
      end
      DONE: begin
        if (accept_s)               state_nxt_s = early_s ? DONE : BUSY;
        else if (bus.div_out_ready) state_nxt_s = IDLE;
        else                        state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
    if (bus.div_cancel) state_nxt_s = IDLE;
    else                state_nxt_s = state_nxt_s;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= state_nxt_s;
  end

  // Datapath: load on acceptance, iterate while BUSY, hold otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_r     <= {(WIDTH+1){1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      dsr_r     <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      neg_rem_r <= 1'b0;
      neg_quo_r <= 1'b0;
      dvz_r     <= 1'b0;
    end else if (accept_s) begin
      dsr_r     <= abs_b_s;
      cnt_r     <= CW'(WIDTH);
      neg_rem_r <= a_neg_s;
      neg_quo_r <= a_neg_s ^ b_neg_s;
      dvz_r     <= (bus.divisor == {WIDTH{1'b0}});
      if (early_s) begin
        rem_r <= {1'b0, abs_a_s};
        quo_r <= {WIDTH{1'b0}};
      end else begin
        rem_r <= {(WIDTH+1){1'b0}};
        quo_r <= abs_a_s;
      end
    end else if (state_r == BUSY) begin
      cnt_r <= cnt_r - CW'(1);
      // The dividend drains out of quo_r's MSB while quotient bits enter its LSB
      if (!diff_s[WIDTH+1]) begin
        rem_r <= diff_s[WIDTH:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= shift_s;
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_r <= rem_r;
      quo_r <= quo_r;
    end
  end

  // Sign fix on the way out; x/0 leaves |dividend| in rem_r, so the fixed remainder is the dividend
  always_comb begin
    q_fix_s = neg_quo_r ? neg2(quo_r) : quo_r;
    r_fix_s = neg_rem_r ? neg2(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
    if (dvz_r) bus.div_result = {r_fix_s, {WIDTH{1'b1}}};
    else       bus.div_result = {r_fix_s, q_fix_s};
    bus.div_in_ready  = in_ready_s;
    bus.div_out_valid = (state_r == DONE);
  end
endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: driver pushes expected results, monitor pops on handshake.
module tb_iter_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  bit   head_seen = 1'b0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb_q[$];

  iter_divider_if #(.WIDTH(W)) bus ();
  iter_divider #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int lat_of(input bit early);
`ifdef DIV_EARLY_OUT_EN
    return early ? 1 : W + 1;
`else
    return W + 1;
`endif
  endfunction

  // Monitor: latency on first valid, result on handshake
  always @(negedge clk) begin
    if (resetn && bus.div_out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 64'(bus.div_out_valid), 64'd0);
      end else begin
        if (!head_seen) begin
          check("latency", 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
          head_seen = 1'b1;
        end
        if (bus.div_out_ready) begin
          check("result", bus.div_result, sb_q[0].res);
          void'(sb_q.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input bit early, input bit ordy);
    bit ok;
    exp_t e;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.div_op        = op;
    bus.dividend      = a;
    bus.divisor       = b;
    bus.div_in_valid  = 1'b1;
    bus.div_out_ready = ordy;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.div_in_ready) begin
        e.res = res; e.lat = lat_of(early); e.acc = cyc;
        sb_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.div_in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  logic [1:0]  v_op  [11];
  logic [31:0] v_a   [11];
  logic [31:0] v_b   [11];
  logic [63:0] v_res [11];
  bit          v_early[11];

  initial begin
    v_op[0]  = 2'b10; v_a[0]  = 32'd100;        v_b[0]  = 32'd7;          v_res[0]  = {32'h00000002, 32'h0000000E}; v_early[0]  = 1'b0;
    v_op[1]  = 2'b01; v_a[1]  = 32'hFFFFFFF9;   v_b[1]  = 32'd2;          v_res[1]  = {32'hFFFFFFFF, 32'hFFFFFFFD}; v_early[1]  = 1'b0;
    v_op[2]  = 2'b01; v_a[2]  = 32'd7;          v_b[2]  = 32'hFFFFFFFE;   v_res[2]  = {32'h00000001, 32'hFFFFFFFD}; v_early[2]  = 1'b0;
    v_op[3]  = 2'b01; v_a[3]  = 32'h80000000;   v_b[3]  = 32'hFFFFFFFF;   v_res[3]  = {32'h00000000, 32'h80000000}; v_early[3]  = 1'b0;
    v_op[4]  = 2'b10; v_a[4]  = 32'd5;          v_b[4]  = 32'd0;          v_res[4]  = {32'h00000005, 32'hFFFFFFFF}; v_early[4]  = 1'b1;
    v_op[5]  = 2'b01; v_a[5]  = 32'hFFFFFFF8;   v_b[5]  = 32'd0;          v_res[5]  = {32'hFFFFFFF8, 32'hFFFFFFFF}; v_early[5]  = 1'b1;
    v_op[6]  = 2'b10; v_a[6]  = 32'd3;          v_b[6]  = 32'd10;         v_res[6]  = {32'h00000003, 32'h00000000}; v_early[6]  = 1'b1;
    v_op[7]  = 2'b11; v_a[7]  = 32'hFFFFFFFA;   v_b[7]  = 32'd3;          v_res[7]  = {32'h00000000, 32'hFFFFFFFE}; v_early[7]  = 1'b0;
    v_op[8]  = 2'b00; v_a[8]  = 32'hFFFFFFFE;   v_b[8]  = 32'd2;          v_res[8]  = {32'h00000000, 32'h7FFFFFFF}; v_early[8]  = 1'b0;
    v_op[9]  = 2'b01; v_a[9]  = 32'hFFFFFFF9;   v_b[9]  = 32'hFFFFFFFE;   v_res[9]  = {32'hFFFFFFFF, 32'h00000003}; v_early[9]  = 1'b0;
    v_op[10] = 2'b10; v_a[10] = 32'hFFFFFFFF;   v_b[10] = 32'd1;          v_res[10] = {32'h00000000, 32'hFFFFFFFF}; v_early[10] = 1'b0;

    bus.div_op = 2'b00; bus.dividend = 32'd0; bus.divisor = 32'd0;
    bus.div_in_valid = 1'b0; bus.div_cancel = 1'b0; bus.div_out_ready = 1'b1;

    #12;
    check("rst_in_ready",  64'(bus.div_in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.div_out_valid), 64'd0);
    check("rst_result",    bus.div_result,         64'd0);
    @(negedge clk); resetn = 1'b1;

    // Back-to-back directed vectors with the consumer always ready
    for (int i = 0; i < 11; i++) issue(v_op[i], v_a[i], v_b[i], v_res[i], v_early[i], 1'b1);
    drain();

    // Hold the result for 10 cycles, then release and accept a new request in the same cycle
    issue(2'b10, 32'd1000, 32'd9, {32'd1, 32'd111}, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.div_out_valid) break;
    end
    check("hold_valid_rise", 64'(bus.div_out_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid",    64'(bus.div_out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.div_in_ready),  64'd0);
      check("hold_result",   bus.div_result,         {32'd1, 32'd111});
    end
    issue(2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b1);
    drain();

    // Cancel mid-BUSY with a competing request that must be ignored
    issue(2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b1);
    repeat (13) @(posedge clk);
    #1;
    bus.div_cancel = 1'b1;
    bus.div_in_valid = 1'b1;
    @(posedge clk); #1;
    bus.div_cancel = 1'b0;
    bus.div_in_valid = 1'b0;
    sb_q.delete();
    check("cancel_in_ready",  64'(bus.div_in_ready),  64'd1);
    check("cancel_out_valid", 64'(bus.div_out_valid), 64'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-BUSY
    issue(2'b01, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_in_ready",  64'(bus.div_in_ready),  64'd1);
    check("arst_out_valid", 64'(bus.div_out_valid), 64'd0);
    check("arst_result",    bus.div_result,         64'd0);
    sb_q.delete();
    @(negedge clk); #2;
    resetn = 1'b1;

    // Functional again after reset
    issue(2'b10, 32'd3, 32'd10, {32'd3, 32'd0}, 1'b1, 1'b1);
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
